// File: rtl/mult_err_pkg.sv
// rtl/mult_err_pkg.sv - shared state encoding and width helpers for the multiplier error sweeper
package mult_err_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FIN    = 2'd3
  } state_e;

  // Product width for a given operand width.
  function automatic int pw(input int width);
    return 2 * width;
  endfunction

  // Sum-of-error-distance width: wide enough that a full sweep cannot wrap.
  function automatic int sw(input int width);
    return 4 * width;
  endfunction

  // Error-count width: holds 2^(2*WIDTH) without wrapping.
  function automatic int cw(input int width);
    return 2 * width + 1;
  endfunction

  localparam int WIDTH_DEF = 8;
  localparam int PW_DEF    = 2 * WIDTH_DEF;
  localparam int SW_DEF    = 4 * WIDTH_DEF;
  localparam int CW_DEF    = 2 * WIDTH_DEF + 1;

endpackage

// File: rtl/mult_err_accum.sv
// rtl/mult_err_accum.sv - error count, summed and maximum error distance accumulators
module mult_err_accum
  import mult_err_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int PW    = pw(WIDTH),
  localparam int SW    = sw(WIDTH),
  localparam int CW    = cw(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic [PW-1:0] exact,
  input  logic [PW-1:0] approx,
  output logic [CW-1:0] err_count,
  output logic [SW-1:0] sum_abs_ed,
  output logic [PW-1:0] max_ed
);

  logic [CW-1:0] diff_pos;
  logic [CW-1:0] diff_neg;
  logic [PW-1:0] ed;

  logic [CW-1:0] err_q, err_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [PW-1:0] max_q, max_d;

  // Absolute error distance; the extra bit makes the sign of exact-approx visible.
  always_comb begin
    diff_pos = {1'b0, exact} - {1'b0, approx};
    diff_neg = {1'b0, approx} - {1'b0, exact};
    ed       = diff_pos[CW-1] ? diff_neg[PW-1:0] : diff_pos[PW-1:0];
  end

  // Next accumulator values if this cycle's pair is accepted.
  always_comb begin
    err_d = err_q + {{(CW-1){1'b0}}, (ed != '0)};
    sum_d = sum_q + {{(SW-PW){1'b0}}, ed};
    max_d = (ed > max_q) ? ed : max_q;
  end

  // Accumulator registers: cleared on a new sweep, updated only on accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else if (clear) begin
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else if (en) begin
      err_q <= err_d;
      sum_q <= sum_d;
      max_q <= max_d;
    end
  end

  assign err_count  = err_q;
  assign sum_abs_ed = sum_q;
  assign max_ed     = max_q;

endmodule

// File: rtl/mult_err_sweeper.sv
// rtl/mult_err_sweeper.sv - sweeps an external multiplier over all operand pairs and scores its error
module mult_err_sweeper
  import mult_err_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int SETTLE = 2,
  localparam int PW     = pw(WIDTH),
  localparam int SW     = sw(WIDTH),
  localparam int CW     = cw(WIDTH),
  localparam int CNTW   = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] am_a,
  output logic [WIDTH-1:0] am_b,
  input  logic [PW-1:0]    am_p,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    err_count,
  output logic [SW-1:0]    sum_abs_ed,
  output logic [PW-1:0]    max_ed
);

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             acc_clear;
  logic             acc_en;
  logic [PW-1:0]    exact;
  logic             last_pair;

  // Reference product and end-of-sweep detection for the pair currently driven.
  always_comb begin
    exact     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    last_pair = (a_q == '1) && (b_q == '1);
  end

  // Sweep sequencing: settle, sample, advance operands; abort returns to IDLE without scoring.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_clear = 1'b1;
          a_d       = '0;
          b_d       = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNTW'(SETTLE - 1)) begin
            state_d = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_en = 1'b1;
          cnt_d  = '0;
          a_d    = a_q + 1'b1;
          if (a_q == '1) begin
            b_d = b_q + 1'b1;
          end
          if (last_pair) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            state_d = DRIVE;
          end
        end
      end
      FIN: begin
        a_d     = '0;
        b_d     = '0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Control and operand registers; every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  mult_err_accum #(
    .WIDTH(WIDTH)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clear     (acc_clear),
    .en        (acc_en),
    .exact     (exact),
    .approx    (am_p),
    .err_count (err_count),
    .sum_abs_ed(sum_abs_ed),
    .max_ed    (max_ed)
  );

  assign am_a = a_q;
  assign am_b = b_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mult_err_sweeper.sv
// tb/tb_mult_err_sweeper.sv - scoreboard bench for the multiplier error sweeper
module tb_mult_err_sweeper;

  localparam int W  = 4;
  localparam int S  = 1;
  localparam int PW = 2 * W;
  localparam int SW = 4 * W;
  localparam int CW = 2 * W + 1;
  // Edges from the one sampling start to the one raising done.
  localparam int SWEEP_EDGES = (1 << (2 * W)) * (S + 1);

  localparam int M_EXACT = 0;
  localparam int M_LSB   = 1;
  localparam int M_ZERO  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  am_a;
  logic [W-1:0]  am_b;
  logic [PW-1:0] am_p;
  logic          busy;
  logic          done;
  logic [CW-1:0] err_count;
  logic [SW-1:0] sum_abs_ed;
  logic [PW-1:0] max_ed;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int mode     = M_EXACT;

  typedef struct {
    bit exp_done;
    int err;
    int sum;
    int mx;
    int end_edge;
  } exp_t;

  exp_t sb_q[$];

  mult_err_sweeper #(
    .WIDTH (W),
    .SETTLE(S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .am_a      (am_a),
    .am_b      (am_b),
    .am_p      (am_p),
    .busy      (busy),
    .done      (done),
    .err_count (err_count),
    .sum_abs_ed(sum_abs_ed),
    .max_ed    (max_ed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Models of the multiplier under test.
  always_comb begin
    logic [PW-1:0] prod;
    prod = {{W{1'b0}}, am_a} * {{W{1'b0}}, am_b};
    case (mode)
      M_LSB:   am_p = prod & ~{{(PW-1){1'b0}}, 1'b1};
      M_ZERO:  am_p = '0;
      default: am_p = prod;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a sweep ends whenever busy falls; pop and compare the expected result.
  initial begin
    bit   prev_busy = 1'b0;
    bit   pulse_chk = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (pulse_chk) begin
        check("done_one_cycle", done, 1'b0);
        pulse_chk = 1'b0;
      end
      if (done === 1'b1) n_done++;
      if (prev_busy && busy === 1'b0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_sweep_end", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("done_flag", done, e.exp_done);
          check("err_count", err_count, e.err);
          check("sum_abs_ed", sum_abs_ed, e.sum);
          check("max_ed", max_ed, e.mx);
          if (e.end_edge >= 0) check("done_edge", cyc, e.end_edge);
          if (e.exp_done) pulse_chk = 1'b1;
        end
      end
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic start_sweep(input int m, input bit exp_done, input int err, input int sum,
                             input int mx, input bit chk_edge);
    exp_t e;
    @(negedge clk);
    mode       = m;
    e.exp_done = exp_done;
    e.err      = err;
    e.sum      = sum;
    e.mx       = mx;
    e.end_edge = chk_edge ? (cyc + 1 + SWEEP_EDGES) : -1;
    sb_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("err_cleared_on_start", err_count, 0);
    check("sum_cleared_on_start", sum_abs_ed, 0);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("sweep_timeout", 1'b1, 1'b0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no end expected end of test");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int done_before;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_am_a", am_a, 0);
    check("rst_am_b", am_b, 0);
    check("rst_err", err_count, 0);
    check("rst_sum", sum_abs_ed, 0);
    check("rst_max", max_ed, 0);
    rst = 1'b0;

    // Exact multiplier, with an operand-order spot check (A is the inner loop).
    start_sweep(M_EXACT, 1'b1, 0, 0, 0, 1'b1);
    check("op_a_first", am_a, 0);
    check("op_b_first", am_b, 0);
    repeat (2) @(negedge clk);
    check("op_a_second", am_a, 1);
    check("op_b_second", am_b, 0);
    repeat (30) @(negedge clk);
    check("op_a_row1", am_a, 0);
    check("op_b_row1", am_b, 1);
    wait_idle(2000);

    // LSB-truncated: only odd*odd products (8*8 pairs) are off by one.
    start_sweep(M_LSB, 1'b1, 64, 64, 1, 1'b1);
    wait_idle(2000);

    // Stuck at zero: 15*15 nonzero products, sum 120^2, max 15*15.
    start_sweep(M_ZERO, 1'b1, 225, 14400, 225, 1'b1);
    wait_idle(2000);

    // Abort in the SAMPLE cycle of pair (A=5, B=3); that pair is not scored.
    start_sweep(M_ZERO, 1'b0, 34, 390, 30, 1'b0);
    done_before = n_done;
    n = 0;
    while (!(am_a == 4'd5 && am_b == 4'd3) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_pair_reached", (am_a == 4'd5 && am_b == 4'd3), 1'b1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("busy_in_abort_sample", busy, 1'b1);
    @(posedge clk);
    #1 abort = 1'b0;
    wait_idle(20);
    repeat (10) @(negedge clk);
    check("abort_no_done", n_done, done_before);
    check("abort_err_held", err_count, 34);
    check("abort_state_idle", dut.state_q, mult_err_pkg::IDLE);

    // Fresh sweep after abort reproduces the full stuck-zero result.
    start_sweep(M_ZERO, 1'b1, 225, 14400, 225, 1'b1);
    wait_idle(2000);

    // A second start mid-sweep changes neither timing nor results.
    start_sweep(M_LSB, 1'b1, 64, 64, 1, 1'b1);
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(2000);

    // Asynchronous reset mid-sweep zeroes outputs before the next edge.
    start_sweep(M_ZERO, 1'b0, 0, 0, 0, 1'b0);
    repeat (77) @(negedge clk);
    check("pre_reset_err_nonzero", (err_count != 0), 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_am_a", am_a, 0);
    check("arst_am_b", am_b, 0);
    check("arst_err", err_count, 0);
    check("arst_sum", sum_abs_ed, 0);
    check("arst_max", max_ed, 0);
    check("arst_state_idle", dut.state_q, mult_err_pkg::IDLE);
    @(negedge clk);
    rst = 1'b0;
    wait_idle(20);

    // Exact sweep after reset: done at the nominal latency, no error.
    start_sweep(M_EXACT, 1'b1, 0, 0, 0, 1'b1);
    wait_idle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_err_sweeper.md
# mult_err_sweeper

Hardware error-characterisation controller for the 8-bit approximate multipliers. It sequences an external combinational multiplier through every operand pair (A, B), waits a programmable settle time per pair, and compares the sampled product against an internally computed exact product. It accumulates error count, sum of absolute error distance and maximum error distance. It sits beside the multiplier under test on silicon or FPGA, so error metrics (ER, MED, NMED, max) come from hardware instead of a long gate-level simulation.

## Interface
- WIDTH, 8, operand width; product is 2*WIDTH bits.
- SETTLE, 2, cycles operands are held before the product is sampled; must be ≥1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled in IDLE; begins a sweep.
- abort  in  1  terminates a sweep in progress.
- am_a  out  WIDTH  operand A to the multiplier under test.
- am_b  out  WIDTH  operand B to the multiplier under test.
- am_p  in  2*WIDTH  product returned by the multiplier under test.
- busy  out  1  high from the cycle after accepted start until the sweep ends.
- done  out  1  one-cycle pulse on sweep completion; not pulsed on abort.
- err_count  out  2*WIDTH+1  number of pairs with am_p ≠ A*B.
- sum_abs_ed  out  4*WIDTH  Σ|A*B − am_p|.
- max_ed  out  2*WIDTH  max |A*B − am_p|.

## Operation
- Reset: FSM=IDLE; am_a, am_b, busy, done, err_count, sum_abs_ed, max_ed all 0.
- **IDLE**
  - start=1 → clear all three accumulators, set am_a=am_b=0 and settle counter=0, go to DRIVE.
  - Accumulators hold previous results until the next accepted start.
- **DRIVE**
  - Operands held stable; the settle counter increments each cycle.
  - After SETTLE cycles in DRIVE, go to SAMPLE.
- **SAMPLE** (one cycle)
  - Compute exact = am_a*am_b (unsigned, 2*WIDTH bits) and ed = |exact − am_p|, with the subtraction done on 2*WIDTH+1 bits.
  - If ed≠0: err_count+=1. Always: sum_abs_ed+=ed; max_ed=max(max_ed, ed).
  - Advance operands: am_a+=1; when am_a wraps from 2^WIDTH−1 to 0, am_b+=1. A is the inner loop.
  - If the pair just sampled was (all-ones, all-ones), go to FIN; otherwise go to DRIVE with the settle counter cleared.
- **FIN** (one cycle)
  - done=1, busy=0, operands return to 0, go to IDLE.
- **Abort**
  - abort=1 in DRIVE or SAMPLE → go to IDLE next cycle: busy=0, no done pulse, accumulators keep their partial values.
  - In a SAMPLE cycle with abort=1, the current pair is **not** accumulated.
  - abort in IDLE or FIN is ignored.
- **Precedence and corner cases**
  - start while busy is ignored; abort has priority over start.
  - Accumulators cannot overflow at WIDTH=8: max sum is 32640² = 1,065,369,600 < 2^32, and err_count ≤ 2^16.
  - Reset mid-sweep clears everything immediately; no completion is reported.

## Timing
- Each pair occupies SETTLE+1 cycles: SETTLE in DRIVE, 1 in SAMPLE.
- Start-to-done latency: start sampled at edge k → busy=1 after edge k; done=1 in cycle k + 2^(2*WIDTH)*(SETTLE+1) + 1, i.e. 196,609 cycles after start for the defaults.
- am_a and am_b change only on the edge leaving SAMPLE, IDLE or FIN. am_p is sampled only in SAMPLE.
- SETTLE × clock period must exceed the multiplier's worst-case combinational delay.
- All outputs are registered.
- Accumulator values are final at the same edge done rises.

## Structure
- Package mult_err_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, FIN);
  - width helper constants (PW=2*WIDTH, SW=4*WIDTH, CW=2*WIDTH+1).
- One sub-module: mult_err_accum, holding the three accumulators.
  - Inputs: clear, en, exact, approx.
  - Computes ed combinationally; registers err_count, sum_abs_ed and max_ed.
- The top level holds the FSM, settle counter and operand counters.

## Test plan
- **Exact model** (am_p = am_a*am_b), defaults: done at start+196,609 cycles; err_count=0, sum_abs_ed=0, max_ed=0.
- **LSB-truncated model** (am_p = (a*b) & ~1): err_count=16384, sum_abs_ed=16384, max_ed=1.
- **Stuck-zero model** (am_p=0): err_count=65025, sum_abs_ed=1,065,369,600, max_ed=65025.
- **Abort** at an arbitrary SAMPLE cycle with the stuck-zero model: busy drops next cycle, no done pulse, and the accumulators equal a reference count over the pairs already sampled, excluding the aborted pair. A subsequent start clears them and a full sweep reproduces the full-sweep values.
- **Start while busy**: a second start pulse mid-sweep has no effect, done occurs at the original cycle, and results are unchanged.
- **Async reset mid-sweep**: rst asserted between edges immediately zeroes all outputs and the FSM is in IDLE. Repeat with WIDTH=4, SETTLE=1: exact-model done at start+513 cycles.
